spi_slave_core: RTL and testbench
=================================

# spi_slave_core

Parametrised SPI slave engine, the next generation of the board's microcontroller link. It runs entirely in the `clk` domain and oversamples `sclk`, `ss` and `mosi` through synchronisers. It supports all four CPOL/CPHA modes, any word width, and multi-word transactions with a word counter. Transmit and receive sides each have a valid/ready handshake, with underrun and overrun flags. It sits between the SPI pins and the FPGA-side command logic.

## Interface
- `DATA_W`, 8: bits per SPI word, 4–32.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `MSB_FIRST`, 1: bit order on both `mosi` and `miso`.
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `CNT_W`, 8: width of `word_count`.
- `TX_IDLE`, all ones: word shifted out when no TX data is held.
- `clk` input 1: system clock (25 MHz on current board).
- `rst` input 1: synchronous, active-high reset.
- `sclk`, `ss`, `mosi` input 1: asynchronous SPI pins; `ss` is active-low.
- `miso` output 1: serial out.
- `miso_oe` output 1: high while the slave is selected; the top level tri-states `miso` on it.
- `tx_data` input DATA_W, `tx_valid` input 1, `tx_ready` output 1: one-entry TX holding register.
- `rx_data` output DATA_W, `rx_valid` output 1, `rx_ready` input 1: received word, held until accepted.
- `rx_overrun`, `tx_underrun` output 1: one-cycle error pulses.
- `word_count` output CNT_W: complete words in the current or last transaction.
- `busy` output 1: state is ACTIVE.
- `xfer_done` output 1: one-cycle pulse at `ss` deassertion.

## Operation
- Every output resets to 0 except `tx_ready`, which resets to 1. Reset also clears `bit_cnt`, the shift registers, the hold register and the state, leaving state DISARMED.
- State machine, `busy` = ACTIVE:
  - DISARMED: move to IDLE once synchronised `ss` is high. This prevents entering mid-frame after a reset.
  - IDLE: on the synchronised `ss` falling edge, clear `word_count` and `bit_cnt` and go to ACTIVE.
  - ACTIVE: on the synchronised `ss` rising edge, pulse `xfer_done` and go to IDLE. A partial word is discarded and `word_count` keeps its value.
- Edge definitions:
  - Leading edge = rising edge of `sclk` when CPOL=0, falling edge when CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge otherwise. Shift edge = the other one.
  - Edges count only in ACTIVE.
- Sample edge:
  - Shift the synchronised `mosi` into the RX shift register in MSB_FIRST order and increment `bit_cnt`.
  - At `bit_cnt` = DATA_W−1, the word is complete: wrap `bit_cnt` to 0 and increment `word_count`, saturating at all ones.
  - If `rx_valid` is low or `rx_ready` is high, copy the word to `rx_data` and set `rx_valid`. Otherwise drop the new word and pulse `rx_overrun`.
  - `rx_valid` clears on a cycle where `rx_valid && rx_ready`.
- TX load events: a shift edge with `bit_cnt` = 0, and additionally ACTIVE entry when CPHA=0.
  - On a load event, if the hold register is full, load the TX shift register from it and set `tx_ready` = 1.
  - If the hold register is empty, load TX_IDLE and pulse `tx_underrun`. No underrun is reported for the load at the shift edge that follows the final word.
  - On any other shift edge, shift the TX register by one bit.
  - `miso` is always driven by the outgoing end of the TX shift register.
- The hold register captures `tx_data` on `tx_valid && tx_ready`, which sets `tx_ready` = 0. A capture and a load in the same cycle pass `tx_data` straight to the shift register, and `tx_ready` stays 1.
- `miso_oe` equals synchronised `ss` inverted, gated by ACTIVE.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 `clk` cycles after an `sclk` or `ss` pin edge.
- `rx_valid` rises SYNC_STAGES+2 cycles after the final sample-edge pin transition.
- `miso` updates SYNC_STAGES+2 cycles after a shift-edge pin transition, and SYNC_STAGES+2 cycles after the `ss` fall when CPHA=0.
- Requirement: each half period of `sclk` is at least (2·SYNC_STAGES+4) `clk` cycles. At 25 MHz and SYNC_STAGES=2 this gives f_sclk ≤ 1.56 MHz.
- `ss` must stay high at least SYNC_STAGES+2 cycles between transactions.
- An `ss` edge and an `sclk` edge detected in the same cycle: the `ss` edge wins.
- `rst` asserted mid-transaction: outputs take their reset values on the next edge. The engine restarts only after `ss` has been seen high.

## Structure
- Package `spi_pkg`: state enum (DISARMED, IDLE, ACTIVE) and mode constants `SPI_MODE0` to `SPI_MODE3`, each a {CPOL,CPHA} pair.
- Sub-module `spi_sync`: SYNC_STAGES-deep synchroniser with registered rise/fall pulses. Instantiated three times, once each for `sclk`, `ss` and `mosi`.

## Test plan
- Mode 0, DATA_W=8, `tx_data`=0xA5 preloaded; master sends 0x3C → `rx_data`=0x3C, `rx_valid` pulse, master receives 0xA5, `word_count`=1, one `xfer_done` pulse.
- Mode 0, DATA_W=8, three back-to-back words 0x01, 0x02, 0x03 with TX refilled on each `tx_ready` → master receives the refilled words, `word_count`=3, no underrun.
- Mode 0, DATA_W=8, `rx_ready` held low across two words 0x11 then 0x22 → `rx_data` stays 0x11, one `rx_overrun` pulse.
- Sweep modes 0–3 with DATA_W=16, LSB-first; master sends 0xBEEF → `rx_data`=0xBEEF in every mode; with TX empty, master receives 0xFFFF and one `tx_underrun` pulse.
- Mode 0, DATA_W=8, `ss` raised after 5 bits → no `rx_valid`, `word_count`=0, `xfer_done` pulse; next full transaction decodes correctly.
- Mode 0, DATA_W=8, `rst` pulsed mid-word while `ss` stays low → all outputs at reset values; no `rx_valid` until `ss` goes high and a fresh frame starts.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine.
package spi_pkg;

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StIdle     = 2'd1,
        StActive   = 2'd2
    } spi_state_e;

    // SPI mode encodings as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for an asynchronous pin, with registered rise/fall pulses.
// level_o is delayed one extra cycle so it lines up with the edge pulses.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave: all four CPOL/CPHA modes, multi-word frames, one-entry TX hold
// register and a held RX word, with overrun/underrun reporting.
module spi_slave_core import spi_pkg::*; #(
    parameter int unsigned          DATA_W      = 8,
    parameter bit                   CPOL        = 1'b0,
    parameter bit                   CPHA        = 1'b0,
    parameter bit                   MSB_FIRST   = 1'b1,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [DATA_W-1:0]    TX_IDLE     = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              xfer_done
);

    localparam int unsigned BitW = $clog2(DATA_W);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .level_o(sclk_lvl), .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .d_i(ss), .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .level_o(mosi_lvl), .rise_o(mosi_rise),
        .fall_o(mosi_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    spi_state_e        state_q, state_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready_q, tx_ready_d;
    logic              xfer_done_q, xfer_done_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              under_pend_q, under_pend_d;

    logic              lead_edge, trail_edge, sample, shift, load, capture;
    logic [DATA_W-1:0] rx_word;

    assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge = CPOL ? sclk_rise : sclk_fall;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_count_d  = word_count_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        xfer_done_d   = 1'b0;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        under_pend_d  = under_pend_q;
        sample        = 1'b0;
        shift         = 1'b0;
        load          = 1'b0;
        capture       = tx_valid && tx_ready_q;
        rx_word       = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_lvl}
                                  : {mosi_lvl, rx_shift_q[DATA_W-1:1]};

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StDisarmed: begin
                if (ss_lvl) state_d = StIdle;
            end
            StIdle: begin
                if (ss_fall) begin
                    state_d      = StActive;
                    word_count_d = '0;
                    bit_cnt_d    = '0;
                    under_pend_d = 1'b0;
                    load         = ~CPHA;
                end
            end
            StActive: begin
                // An ss edge masks any sclk edge seen in the same cycle.
                if (ss_rise) begin
                    state_d      = StIdle;
                    xfer_done_d  = 1'b1;
                    under_pend_d = 1'b0;
                end else begin
                    sample = CPHA ? trail_edge : lead_edge;
                    shift  = CPHA ? lead_edge : trail_edge;
                end
            end
            default: state_d = StDisarmed;
        endcase

        if (sample) begin
            rx_shift_d = rx_word;
            // A deferred underrun is only real once the idle word actually starts shifting.
            if (under_pend_q && bit_cnt_q == '0) begin
                tx_underrun_d = 1'b1;
                under_pend_d  = 1'b0;
            end
            if (bit_cnt_q == LastBit) begin
                bit_cnt_d = '0;
                if (word_count_q != '1) word_count_d = word_count_q + CNT_W'(1);
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d  = rx_word;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
        end

        if (shift) begin
            if (bit_cnt_q == '0) begin
                load = 1'b1;
            end else begin
                tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b1}
                                       : {1'b1, tx_shift_q[DATA_W-1:1]};
            end
        end

        if (load) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else if (capture) begin
                tx_shift_d = tx_data;
            end else begin
                tx_shift_d = TX_IDLE;
                // With CPHA=0 the load after the last word of a frame is not an underrun.
                if (!CPHA && shift) under_pend_d = 1'b1;
                else                tx_underrun_d = 1'b1;
            end
        end else if (capture) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StDisarmed;
            bit_cnt_q     <= '0;
            word_count_q  <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            xfer_done_q   <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            under_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_count_q  <= word_count_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            xfer_done_q   <= xfer_done_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            under_pend_q  <= under_pend_d;
        end
    end

    assign miso        = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
    assign miso_oe     = ~ss_lvl & (state_q == StActive);
    assign busy        = (state_q == StActive);
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign word_count  = word_count_q;
    assign xfer_done   = xfer_done_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one 8-bit mode-0 MSB-first instance plus four 16-bit LSB-first
// instances (modes 0-3), driven one at a time by a shared bit-banged SPI master.
module tb_spi_slave_core;

    localparam int H = 10;  // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        m_sclk, m_ss, m_mosi, m_rx_ready, m_tx_valid;
    logic [31:0] m_tx_data;
    logic [2:0]  sel;

    logic        m_miso, m_miso_oe, m_tx_ready, m_rx_valid, m_rx_overrun, m_tx_underrun;
    logic        m_busy, m_xfer_done;
    logic [31:0] m_rx_data;
    logic [7:0]  m_wc;

    always #5 clk = ~clk;

    // Main instance: mode 0, 8-bit, MSB first.
    logic       sclk0, ss0, tx_valid0;
    logic       miso0, miso_oe0, tx_ready0, rx_valid0, rx_overrun0, tx_underrun0, busy0;
    logic       xfer_done0;
    logic [7:0] rx_data0, word_count0;

    assign sclk0     = (sel == 3'd4) ? m_sclk : 1'b0;
    assign ss0       = (sel == 3'd4) ? m_ss : 1'b1;
    assign tx_valid0 = (sel == 3'd4) && m_tx_valid;

    spi_slave_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss0), .mosi(m_mosi), .miso(miso0),
        .miso_oe(miso_oe0), .tx_data(m_tx_data[7:0]), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(m_rx_ready), .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0),
        .word_count(word_count0), .busy(busy0), .xfer_done(xfer_done0)
    );

    // Sweep instances: 16-bit, LSB first, mode = index.
    logic        sw_sclk [4], sw_ss [4], sw_tx_valid [4];
    logic        sw_miso [4], sw_miso_oe [4], sw_tx_ready [4], sw_rx_valid [4];
    logic        sw_rx_overrun [4], sw_tx_underrun [4], sw_busy [4], sw_xfer_done [4];
    logic [15:0] sw_rx_data [4];
    logic [7:0]  sw_wc [4];

    for (genvar i = 0; i < 4; i++) begin : gen_sw
        assign sw_sclk[i]     = (sel == 3'(i)) ? m_sclk : ((i >= 2) ? 1'b1 : 1'b0);
        assign sw_ss[i]       = (sel == 3'(i)) ? m_ss : 1'b1;
        assign sw_tx_valid[i] = (sel == 3'(i)) && m_tx_valid;

        spi_slave_core #(
            .DATA_W(16), .CPOL(i >= 2), .CPHA((i % 2) == 1), .MSB_FIRST(1'b0)
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sw_sclk[i]), .ss(sw_ss[i]), .mosi(m_mosi),
            .miso(sw_miso[i]), .miso_oe(sw_miso_oe[i]), .tx_data(m_tx_data[15:0]),
            .tx_valid(sw_tx_valid[i]), .tx_ready(sw_tx_ready[i]), .rx_data(sw_rx_data[i]),
            .rx_valid(sw_rx_valid[i]), .rx_ready(m_rx_ready), .rx_overrun(sw_rx_overrun[i]),
            .tx_underrun(sw_tx_underrun[i]), .word_count(sw_wc[i]), .busy(sw_busy[i]),
            .xfer_done(sw_xfer_done[i])
        );
    end

    always_comb begin
        if (sel == 3'd4) begin
            m_miso = miso0; m_miso_oe = miso_oe0; m_tx_ready = tx_ready0;
            m_rx_valid = rx_valid0; m_rx_overrun = rx_overrun0; m_tx_underrun = tx_underrun0;
            m_busy = busy0; m_xfer_done = xfer_done0; m_rx_data = {24'h0, rx_data0};
            m_wc = word_count0;
        end else begin
            m_miso = sw_miso[sel[1:0]]; m_miso_oe = sw_miso_oe[sel[1:0]];
            m_tx_ready = sw_tx_ready[sel[1:0]]; m_rx_valid = sw_rx_valid[sel[1:0]];
            m_rx_overrun = sw_rx_overrun[sel[1:0]]; m_tx_underrun = sw_tx_underrun[sel[1:0]];
            m_busy = sw_busy[sel[1:0]]; m_xfer_done = sw_xfer_done[sel[1:0]];
            m_rx_data = {16'h0, sw_rx_data[sel[1:0]]}; m_wc = sw_wc[sel[1:0]];
        end
    end

    // Monitor: logs each new received word and counts the pulse outputs.
    logic [31:0] obs_q [$];
    logic        prev_v = 1'b0;
    int          n_done = 0, n_ovr = 0, n_und = 0;

    always @(negedge clk) begin
        if (m_rx_valid && !prev_v) obs_q.push_back(m_rx_data);
        prev_v = m_rx_valid;
        if (m_xfer_done)   n_done++;
        if (m_rx_overrun)  n_ovr++;
        if (m_tx_underrun) n_und++;
    end

    int          checks = 0, failures = 0, rd_idx = 0;
    logic [31:0] exp_q [$];
    logic [31:0] tx_words [4];
    logic [31:0] rx_words [4];
    int          cur_w;
    logic        cur_cpol, cur_cpha, cur_msb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        int t = 0;
        logic [31:0] e;
        while (obs_q.size() <= rd_idx && t < 500) begin
            @(negedge clk);
            t++;
        end
        e = exp_q.pop_front();
        if (obs_q.size() > rd_idx) begin
            check(tag, obs_q[rd_idx], e);
            rd_idx++;
        end else begin
            check({tag, "_timeout"}, obs_q.size(), rd_idx + 1);
        end
    endtask

    task automatic tx_push(input logic [31:0] d);
        int t = 0;
        while (!m_tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", m_tx_ready, 32'd1);
        m_tx_data  = d;
        m_tx_valid = 1'b1;
        @(negedge clk);
        m_tx_valid = 1'b0;
    endtask

    task automatic spi_word(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        int idx;
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            idx = cur_msb ? cur_w - 1 - b : b;
            if (!cur_cpha) begin
                m_mosi = tx[idx];
                wait_clks(H);
                m_sclk  = ~cur_cpol;
                rx[idx] = m_miso;
                wait_clks(H);
                m_sclk = cur_cpol;
            end else begin
                m_sclk = ~cur_cpol;
                m_mosi = tx[idx];
                wait_clks(H);
                m_sclk  = cur_cpol;
                rx[idx] = m_miso;
                wait_clks(H);
            end
        end
    endtask

    task automatic spi_frame(input int n);
        m_sclk = cur_cpol;
        m_ss   = 1'b0;
        wait_clks(H);
        for (int k = 0; k < n; k++) spi_word(tx_words[k], cur_w, rx_words[k]);
        wait_clks(H);
        m_ss = 1'b1;
        wait_clks(2 * H);
    endtask

    initial begin
        int d_done, d_ovr, d_und;
        logic [31:0] tmp;

        rst = 1'b1; m_ss = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0; m_rx_ready = 1'b1;
        m_tx_valid = 1'b0; m_tx_data = '0; sel = 3'd4;
        cur_w = 8; cur_cpol = 1'b0; cur_cpha = 1'b0; cur_msb = 1'b1;
        wait_clks(3);
        check("rst_rx_valid", m_rx_valid, 0);
        check("rst_tx_ready", m_tx_ready, 1);
        check("rst_busy", m_busy, 0);
        check("rst_word_count", m_wc, 0);
        check("rst_rx_data", m_rx_data, 0);
        check("rst_miso", m_miso, 0);
        check("rst_miso_oe", m_miso_oe, 0);
        rst = 1'b0;
        wait_clks(10);

        // Single word, TX preloaded.
        tx_push(32'hA5);
        check("t1_tx_ready_low", m_tx_ready, 0);
        d_done = n_done; d_und = n_und;
        exp_q.push_back(32'h3C);
        tx_words[0] = 32'h3C;
        spi_frame(1);
        check("t1_master_rx", rx_words[0], 32'hA5);
        check_rx("t1_rx_data");
        check("t1_word_count", m_wc, 1);
        check("t1_xfer_done", n_done - d_done, 1);
        check("t1_no_underrun", n_und - d_und, 0);

        // Three words, TX refilled as the hold register frees.
        tx_push(32'h81);
        d_und = n_und;
        tx_words[0] = 32'h01; tx_words[1] = 32'h02; tx_words[2] = 32'h03;
        exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h03);
        fork
            spi_frame(3);
            begin
                tx_push(32'h82);
                tx_push(32'h83);
            end
        join
        check("t2_master_rx0", rx_words[0], 32'h81);
        check("t2_master_rx1", rx_words[1], 32'h82);
        check("t2_master_rx2", rx_words[2], 32'h83);
        check_rx("t2_rx0");
        check_rx("t2_rx1");
        check_rx("t2_rx2");
        check("t2_word_count", m_wc, 3);
        check("t2_no_underrun", n_und - d_und, 0);

        // Overrun: consumer stalled across two words.
        m_rx_ready = 1'b0;
        d_ovr = n_ovr;
        tx_words[0] = 32'h11; tx_words[1] = 32'h22;
        exp_q.push_back(32'h11);
        spi_frame(2);
        check_rx("t3_rx_first");
        check("t3_rx_data_held", m_rx_data, 32'h11);
        check("t3_rx_valid_held", m_rx_valid, 1);
        check("t3_overrun", n_ovr - d_ovr, 1);
        check("t3_word_count", m_wc, 2);
        m_rx_ready = 1'b1;
        wait_clks(2);
        check("t3_rx_valid_clear", m_rx_valid, 0);

        // Frame aborted after 5 bits, then a normal frame.
        d_done = n_done;
        m_ss = 1'b0;
        wait_clks(H);
        spi_word(32'h9F, 5, tmp);
        wait_clks(H);
        m_ss = 1'b1;
        wait_clks(2 * H);
        check("t5_no_rx", obs_q.size(), rd_idx);
        check("t5_word_count", m_wc, 0);
        check("t5_xfer_done", n_done - d_done, 1);
        tx_words[0] = 32'h5A;
        exp_q.push_back(32'h5A);
        spi_frame(1);
        check_rx("t5_next_rx");
        check("t5_next_word_count", m_wc, 1);

        // Reset mid-word with ss held low.
        m_ss = 1'b0;
        wait_clks(H);
        spi_word(32'hF0, 3, tmp);
        rst = 1'b1;
        wait_clks(2);
        check("t6_rx_valid", m_rx_valid, 0);
        check("t6_rx_data", m_rx_data, 0);
        check("t6_busy", m_busy, 0);
        check("t6_tx_ready", m_tx_ready, 1);
        check("t6_word_count", m_wc, 0);
        check("t6_miso_oe", m_miso_oe, 0);
        rst = 1'b0;
        spi_word(32'hF0, 5, tmp);
        spi_word(32'h77, 8, tmp);
        wait_clks(H);
        check("t6_no_rx_disarmed", obs_q.size(), rd_idx);
        check("t6_busy_disarmed", m_busy, 0);
        m_ss = 1'b1;
        wait_clks(2 * H);
        tx_words[0] = 32'hC3;
        exp_q.push_back(32'hC3);
        spi_frame(1);
        check_rx("t6_fresh_rx");
        check("t6_fresh_word_count", m_wc, 1);

        // Mode sweep, 16-bit LSB first, TX empty.
        cur_w = 16; cur_msb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_cpol = (i >= 2);
            cur_cpha = (i % 2) == 1;
            m_sclk   = cur_cpol;
            sel      = 3'(i);
            wait_clks(5);
            d_und = n_und; d_done = n_done;
            tx_words[0] = 32'hBEEF;
            exp_q.push_back(32'hBEEF);
            spi_frame(1);
            check($sformatf("sw%0d_master_rx", i), rx_words[0], 32'hFFFF);
            check_rx($sformatf("sw%0d_rx_data", i));
            check($sformatf("sw%0d_underrun", i), n_und - d_und, 1);
            check($sformatf("sw%0d_xfer_done", i), n_done - d_done, 1);
            check($sformatf("sw%0d_word_count", i), m_wc, 1);
            check($sformatf("sw%0d_idle", i), m_busy, 0);
        end
        m_sclk = 1'b0;
        sel    = 3'd4;
        wait_clks(5);

        check("no_extra_rx", obs_q.size(), rd_idx);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
